escaner_teclado: RTL and testbench
==================================

Name: escaner_teclado

Overview:
- Scans a 4x4 matrix keypad, debounces a single key press, and decodes it.
- Emits one-cycle command pulses that drive the digit-capture register directly downstream:
  - digit keys produce `capturar` plus `digito`;
  - `*` produces `clear`;
  - `#` produces `enter`;
  - A–D produce an operator pulse.
- Sits between the board keypad pins and the number-entry datapath.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before advancing (≥4).
- DEBOUNCE_CYCLES, 200000: consecutive stable synchronized cycles required to accept a press or a release (≥2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- filas  input  4  keypad rows; active-low, externally pulled up; asynchronous to clk.
- columnas  output  4  keypad column drive; active-low, exactly one bit low at all times.
- digito  output  4  BCD value of the last accepted digit key (0–9).
- capturar  output  1  one-cycle pulse: digit key accepted; `digito` is valid in the same cycle.
- clear  output  1  one-cycle pulse: `*` accepted.
- enter  output  1  one-cycle pulse: `#` accepted.
- op_valido  output  1  one-cycle pulse: A/B/C/D accepted.
- op_codigo  output  2  A=0, B=1, C=2, D=3; valid with `op_valido`.
- tecla_activa  output  1  level: high from press acceptance until release acceptance.

Behaviour:
- Reset (reset=0, async):
  - FSM enters ESCANEO; column index = 0; columnas = 4'b1110.
  - digito = 0, op_codigo = 0; all pulses 0; tecla_activa = 0.
  - Counters and synchronizer flops are cleared; synchronizer flops are cleared to 4'hF.
- `filas` passes through a 2-flop synchronizer; all decisions use the synchronized value fs.
- Key map (row, col):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- ESCANEO:
  - columnas = ~(1 << col).
  - Dwell counter runs 0..SCAN_DIV-1. fs is sampled only in the last dwell cycle, to allow settling.
  - If fs == 4'hF at the sample: col advances (3 wraps to 0) and the dwell counter restarts.
  - If fs has exactly one bit low: latch row/col, clear the debounce counter, go REBOTE. The column stays driven.
  - If fs has two or more bits low: treat as no press and advance the column.
- REBOTE:
  - Column is held. The counter increments each cycle while fs equals the latched row pattern.
  - Any mismatch (including release or a second row) → ESCANEO, advancing to the next column, no pulse.
  - On the cycle the counter reaches DEBOUNCE_CYCLES-1 with fs still matching → EMITIR.
- EMITIR (exactly 1 cycle):
  - Assert exactly one pulse per the key map.
  - digito / op_codigo are updated in the same cycle and hold afterwards.
  - tecla_activa rises this cycle.
  - Next state is ESPERA_SOLTAR.
- ESPERA_SOLTAR:
  - Column is held. The counter counts consecutive cycles with fs == 4'hF.
  - Any low bit restarts the counter at 0.
  - On reaching DEBOUNCE_CYCLES-1 → tecla_activa falls; go ESCANEO with col+1.
- A held key generates exactly one pulse; there is no auto-repeat.
- Other keys pressed while a key is held are ignored, since only the held column is driven.
- Pulses are mutually exclusive and never asserted in two consecutive cycles.
- Press latency from a clean fs edge to the pulse: DEBOUNCE_CYCLES+1 cycles; add 2 cycles from the pin.
- An async reset mid-press aborts with no pulse. After reset, the still-held key is re-detected through a full debounce.
- All outputs are registered.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset released, no key: columnas cycles 1110→1101→1011→0111→1110, 4 cycles each; no pulses; tecla_activa=0.
- Press key "5" (row1/col1) cleanly for 40 cycles, then release:
  - capturar=1 for exactly 1 cycle with digito=5;
  - tecla_activa high until 8 clean released cycles elapse.
- Press `*`, then later `#`, then `C`: clear, enter, and op_valido with op_codigo=2, each a single pulse; digito is unchanged.
- Bounce key "9": toggle every 3 cycles for 20 cycles, then hold stable → exactly one capturar with digito=9, occurring 9 cycles after the stable hold begins (synchronized).
- Press "1" and "4" simultaneously (col0, rows 0 and 1) → no pulse; scanning continues. Release "4" → capturar with digito=1.
- Assert reset during REBOTE of key "0" → all outputs return to reset values immediately. Keep "0" held after reset release → exactly one capturar, digito=0.

Source files
------------

// File: rtl/escaner_teclado.sv
// ---------------------------------------------------------------------------
// escaner_teclado
//   Scans a 4x4 active-low matrix keypad, debounces a single key press and
//   release, and turns each accepted press into exactly one command pulse for
//   the number-entry datapath.
//
//   Key map (row, col):
//       r0: 1 2 3 A
//       r1: 4 5 6 B
//       r2: 7 8 9 C
//       r3: * 0 # D
//
// Parameters
//   SCAN_DIV         cycles each column is driven before advancing (>= 4)
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept a press/release (>= 2)
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   filas[3:0]    keypad rows, active-low, asynchronous to clk
//   columnas[3:0] column drive, active-low, exactly one bit low
//   digito[3:0]   BCD value of the last accepted digit key
//   capturar      one-cycle pulse, digit key accepted (digito valid with it)
//   clear         one-cycle pulse, '*' accepted
//   enter         one-cycle pulse, '#' accepted
//   op_valido     one-cycle pulse, A/B/C/D accepted
//   op_codigo     operator code A=0 .. D=3, valid with op_valido
//   tecla_activa  level, high from press acceptance until release acceptance
// ---------------------------------------------------------------------------
module escaner_teclado #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [3:0] digito,
    output logic       capturar,
    output logic       clear,
    output logic       enter,
    output logic       op_valido,
    output logic [1:0] op_codigo,
    output logic       tecla_activa
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ESCANEO,
        REBOTE,
        EMITIR,
        ESPERA_SOLTAR
    } estado_t;

    estado_t          estado;
    logic [1:0]       col;
    logic [3:0]       patron;
    logic [DIV_W-1:0] dwell;
    logic [DEB_W-1:0] deb;
    logic [3:0]       filas_p0;
    logic [3:0]       fs_p1;

    // Active-low drive pattern for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    // True when exactly one row line is pulled low.
    function automatic logic una_fila(input logic [3:0] f);
        return ($countones(~f) == 1);
    endfunction

    // Row index of a one-low row pattern.
    function automatic logic [1:0] fila_de(input logic [3:0] f);
        logic [1:0] r;
        case (f)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    // Digit value of a key in rows 0..2, columns 0..2 (1..9, row-major).
    function automatic logic [3:0] digito_de(input logic [1:0] f, input logic [1:0] c);
        return ({2'b00, f} * 4'd3) + {2'b00, c} + 4'd1;
    endfunction

    // ---- stage p0/p1: two-flop synchronizer on the raw row inputs ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filas_p0 <= 4'hF;
            fs_p1    <= 4'hF;
        end else begin
            filas_p0 <= filas;
            fs_p1    <= filas_p0;
        end
    end

    // ---- stage p2: scan / debounce FSM with registered outputs ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado       <= ESCANEO;
            col          <= 2'd0;
            columnas     <= 4'b1110;
            patron       <= 4'hF;
            dwell        <= '0;
            deb          <= '0;
            digito       <= 4'd0;
            op_codigo    <= 2'd0;
            capturar     <= 1'b0;
            clear        <= 1'b0;
            enter        <= 1'b0;
            op_valido    <= 1'b0;
            tecla_activa <= 1'b0;
        end else begin
            capturar  <= 1'b0;
            clear     <= 1'b0;
            enter     <= 1'b0;
            op_valido <= 1'b0;

            case (estado)
                ESCANEO: begin
                    // Rows are looked at only in the last dwell cycle so the
                    // freshly driven column has time to settle through the
                    // synchronizer.
                    if (dwell == DIV_MAX) begin
                        dwell <= '0;
                        if (una_fila(fs_p1)) begin
                            patron <= fs_p1;
                            deb    <= '0;
                            estado <= REBOTE;
                        end else begin
                            col      <= col + 2'd1;
                            columnas <= col_drive(col + 2'd1);
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end

                REBOTE: begin
                    if (fs_p1 == patron) begin
                        if (deb == DEB_MAX) begin
                            // Outputs are loaded here so they are visible
                            // during the single EMITIR cycle.
                            estado       <= EMITIR;
                            tecla_activa <= 1'b1;
                            if (col == 2'd3) begin
                                op_valido <= 1'b1;
                                op_codigo <= fila_de(patron);
                            end else if (fila_de(patron) == 2'd3) begin
                                case (col)
                                    2'd0:    clear <= 1'b1;
                                    2'd1: begin
                                        capturar <= 1'b1;
                                        digito   <= 4'd0;
                                    end
                                    default: enter <= 1'b1;
                                endcase
                            end else begin
                                capturar <= 1'b1;
                                digito   <= digito_de(fila_de(patron), col);
                            end
                        end else begin
                            deb <= deb + 1'b1;
                        end
                    end else begin
                        // Bounce, release or a second row: abandon quietly.
                        estado   <= ESCANEO;
                        dwell    <= '0;
                        col      <= col + 2'd1;
                        columnas <= col_drive(col + 2'd1);
                    end
                end

                EMITIR: begin
                    deb    <= '0;
                    estado <= ESPERA_SOLTAR;
                end

                ESPERA_SOLTAR: begin
                    // Only the held column is driven, so other keys cannot
                    // disturb the release count.
                    if (fs_p1 != 4'hF) begin
                        deb <= '0;
                    end else if (deb == DEB_MAX) begin
                        tecla_activa <= 1'b0;
                        estado       <= ESCANEO;
                        dwell        <= '0;
                        col          <= col + 2'd1;
                        columnas     <= col_drive(col + 2'd1);
                    end else begin
                        deb <= deb + 1'b1;
                    end
                end

                default: begin
                    estado <= ESCANEO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_escaner_teclado.sv
module tb_escaner_teclado;

    localparam int SD  = 4;
    localparam int DEB = 8;

    logic       clk;
    logic       reset;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [3:0] digito;
    logic       capturar;
    logic       clear;
    logic       enter;
    logic       op_valido;
    logic [1:0] op_codigo;
    logic       tecla_activa;

    // Pressed-key mask, index = row*4 + col.
    logic [15:0] teclas;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_pulse_cyc = 0;
    logic prev_pulse = 1'b0;

    // kind: 0 capturar (val = digito), 1 clear, 2 enter, 3 op (val = op_codigo)
    typedef struct {
        int kind;
        int val;
    } ev_t;
    ev_t sb[$];

    escaner_teclado #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk          (clk),
        .reset        (reset),
        .filas        (filas),
        .columnas     (columnas),
        .digito       (digito),
        .capturar     (capturar),
        .clear        (clear),
        .enter        (enter),
        .op_valido    (op_valido),
        .op_codigo    (op_codigo),
        .tecla_activa (tecla_activa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a row is pulled low when a pressed key sits on a driven column.
    always_comb begin
        filas = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (teclas[r*4+c] && !columnas[c]) filas[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_columnas"}, columnas, 4'b1110);
        chk({tag, "_digito"}, digito, 0);
        chk({tag, "_op_codigo"}, op_codigo, 0);
        chk({tag, "_pulses"}, {capturar, clear, enter, op_valido}, 0);
        chk({tag, "_tecla_activa"}, tecla_activa, 0);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, sb.size(), 0);
    endtask

    task automatic wait_libre(input string tag, input int budget);
        int n = 0;
        while (tecla_activa !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, tecla_activa, 0);
    endtask

    task automatic wait_col(input string tag, input logic [3:0] v, input int budget);
        int n = 0;
        while (columnas !== v && n < budget) begin
            tick();
            n++;
        end
        chk(tag, columnas, v);
    endtask

    task automatic pulsar(input string tag, input int idx, input int kind, input int val);
        sb.push_back('{kind, val});
        teclas[idx] = 1'b1;
        drain({tag, "_pulse"}, 80);
        repeat (5) tick();
        chk({tag, "_held"}, tecla_activa, 1);
        teclas[idx] = 1'b0;
        wait_libre({tag, "_release"}, 60);
    endtask

    // Output monitor: every pulse is popped against the scoreboard.
    always @(negedge clk) begin
        int n;
        int k;
        int v;
        n = int'(capturar) + int'(clear) + int'(enter) + int'(op_valido);
        chk("columnas_one_low", $countones(~columnas), 1);
        if (n != 0) begin
            chk("pulse_exclusive", n, 1);
            chk("pulse_not_consecutive", prev_pulse, 0);
            k = capturar ? 0 : clear ? 1 : enter ? 2 : 3;
            v = capturar ? int'(digito) : op_valido ? int'(op_codigo) : 0;
            chk("pulse_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                ev_t e;
                e = sb.pop_front();
                chk("pulse_kind", k, e.kind);
                chk("pulse_value", v, e.val);
            end
            last_pulse_cyc = cyc;
        end
        prev_pulse = (n != 0);
        cyc++;
    end

    initial begin
        int t0;
        teclas = '0;
        reset  = 1'b1;
        #1 reset = 1'b0;
        repeat (3) tick();
        chk_reset_vals("rst");

        // Idle scan: each column driven for SD cycles, in order.
        reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            logic [3:0] e;
            e = ~(4'b0001 << ((i / SD) % 4));
            chk("idle_scan", columnas, e);
            chk("idle_tecla", tecla_activa, 0);
            tick();
        end

        // Key "5" held 40 cycles, then release timing of tecla_activa.
        sb.push_back('{0, 5});
        teclas[5] = 1'b1;
        repeat (40) tick();
        chk("k5_pulse_seen", sb.size(), 0);
        chk("k5_tecla_high", tecla_activa, 1);
        chk("k5_digito_hold", digito, 5);
        teclas[5] = 1'b0;
        repeat (9) tick();
        chk("k5_tecla_still_high", tecla_activa, 1);
        tick();
        chk("k5_tecla_low", tecla_activa, 0);

        // '*', '#', 'C' leave digito untouched.
        pulsar("star", 12, 1, 0);
        pulsar("hash", 14, 2, 0);
        pulsar("keyC", 11, 3, 2);
        chk("digito_unchanged", digito, 5);
        chk("op_codigo_C", op_codigo, 2);

        // Bouncing "9": toggles every 3 cycles, then stable.
        for (int i = 0; i < 20; i++) begin
            teclas[10] = ((i / 3) % 2 == 0);
            tick();
        end
        chk("k9_no_pulse_during_bounce", sb.size(), 0);
        sb.push_back('{0, 9});
        teclas[10] = 1'b1;
        t0 = cyc;
        drain("k9_pulse", 80);
        chk("k9_latency_min", (last_pulse_cyc - t0) >= DEB + 1, 1);
        teclas[10] = 1'b0;
        wait_libre("k9_release", 60);

        // "1" and "4" together: ignored, scan keeps moving.
        teclas[0] = 1'b1;
        teclas[4] = 1'b1;
        repeat (40) tick();
        chk("dual_tecla_low", tecla_activa, 0);
        wait_col("dual_scan_c1", 4'b1101, 20);
        wait_col("dual_scan_c0", 4'b1110, 20);
        sb.push_back('{0, 1});
        teclas[4] = 1'b0;
        drain("k1_pulse", 80);
        teclas[0] = 1'b0;
        wait_libre("k1_release", 60);

        // Reset during debounce of "0", then re-detect after reset.
        wait_col("k0_wait_c0", 4'b1110, 20);
        teclas[13] = 1'b1;
        wait_col("k0_wait_c1", 4'b1101, 20);
        repeat (5) tick();
        chk("k0_no_pulse_yet", tecla_activa, 0);
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        reset = 1'b1;
        sb.push_back('{0, 0});
        drain("k0_pulse", 80);
        chk("k0_digito", digito, 0);
        teclas[13] = 1'b0;
        wait_libre("k0_release", 60);
        repeat (10) tick();
        chk("sb_empty_end", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
